// File: rtl/fifo_sync_multi.sv
// Multi-channel synchronous FIFO: pCHANNELS independent queues sharing one
// memory addressed {channel, pointer}, with per-channel status and sticky error flags.
module fifo_sync_multi #(
  parameter int pDATA_WIDTH = 16,
  parameter int pDEPTH      = 512,
  parameter int pCHANNELS   = 4,
  localparam int CW = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1,
  localparam int AW = $clog2(pDEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            full_threshold_value,
  input  logic [31:0]            empty_threshold_value,
  input  logic [pCHANNELS-1:0]   clear,
  input  logic                   wen,
  input  logic [CW-1:0]          wchan,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   ren,
  input  logic [CW-1:0]          rchan,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rvalid,
  output logic [AW:0]            rlevel,
  output logic [pCHANNELS-1:0]   full,
  output logic [pCHANNELS-1:0]   almost_full,
  output logic [pCHANNELS-1:0]   full_threshold,
  output logic [pCHANNELS-1:0]   overflow,
  output logic [pCHANNELS-1:0]   empty,
  output logic [pCHANNELS-1:0]   almost_empty,
  output logic [pCHANNELS-1:0]   empty_threshold,
  output logic [pCHANNELS-1:0]   underflow
);

  localparam int MW = CW + AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(pDEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(pDEPTH - 1);

  logic [pCHANNELS-1:0]         wr_acc, rd_acc;
  logic [pCHANNELS-1:0][AW:0]   count_all;
  logic [pCHANNELS-1:0][AW-1:0] wptr_all, rptr_all;

  // Channels whose index is >= pCHANNELS never match a generated channel,
  // so out-of-range strobes are silently ignored.
  for (genvar gi = 0; gi < pCHANNELS; gi++) begin : g_chan
    logic          wr_hit, rd_hit, cnt_full, cnt_empty, wr_drop, rd_drop;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;

    assign wr_hit    = wen && (wchan == CW'(gi));
    assign rd_hit    = ren && (rchan == CW'(gi));
    assign cnt_full  = (count_q == DEPTH_CNT);
    assign cnt_empty = (count_q == '0);

    // Acceptance looks only at the pre-edge count, so a same-cycle read
    // cannot rescue a write to a full channel (and vice versa).
    assign wr_acc[gi] = wr_hit && !clear[gi] && !cnt_full;
    assign rd_acc[gi] = rd_hit && !clear[gi] && !cnt_empty;
    assign wr_drop    = wr_hit && !clear[gi] && cnt_full;
    assign rd_drop    = rd_hit && !clear[gi] && cnt_empty;

    always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q | wr_drop;
      unf_d   = unf_q | rd_drop;
      if (clear[gi]) begin
        wptr_d  = '0;
        rptr_d  = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end else begin
        if (wr_acc[gi]) wptr_d = wptr_q + 1'b1;
        if (rd_acc[gi]) rptr_d = rptr_q + 1'b1;
        if (wr_acc[gi] && !rd_acc[gi])      count_d = count_q + 1'b1;
        else if (!wr_acc[gi] && rd_acc[gi]) count_d = count_q - 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
        ovf_q   <= ovf_d;
        unf_q   <= unf_d;
      end
    end

    assign count_all[gi]       = count_q;
    assign wptr_all[gi]        = wptr_q;
    assign rptr_all[gi]        = rptr_q;
    assign full[gi]            = cnt_full;
    assign empty[gi]           = cnt_empty;
    assign almost_full[gi]     = (count_q == AFULL_CNT);
    assign almost_empty[gi]    = (count_q == (AW+1)'(1));
    assign full_threshold[gi]  = (32'(count_q) >= full_threshold_value);
    assign empty_threshold[gi] = (32'(count_q) <= empty_threshold_value);
    assign overflow[gi]        = ovf_q;
    assign underflow[gi]       = unf_q;
  end

  logic [AW-1:0] waddr_ptr, raddr_ptr;
  logic [MW-1:0] waddr, raddr;
  logic          wr_any, rd_any;

  always_comb begin
    waddr_ptr = '0;
    raddr_ptr = '0;
    rlevel    = '0;
    for (int c = 0; c < pCHANNELS; c++) begin
      if (wr_acc[c]) waddr_ptr = wptr_all[c];
      if (rd_acc[c]) raddr_ptr = rptr_all[c];
      if (rchan == CW'(c)) rlevel = count_all[c];
    end
  end

  assign wr_any = |wr_acc;
  assign rd_any = |rd_acc;
  assign waddr  = {wchan, waddr_ptr};
  assign raddr  = {rchan, raddr_ptr};

  // Memory and its read register carry no reset so they map onto block RAM.
  // A read and write never collide on one address: that needs a count of
  // 0 or pDEPTH, where one of the two is dropped.
  logic [pDATA_WIDTH-1:0] mem_q [pCHANNELS*pDEPTH];
  logic [pDATA_WIDTH-1:0] rd_word_q;

  always_ff @(posedge clk) begin
    if (wr_any) mem_q[waddr] <= wdata;
    if (rd_any) rd_word_q <= mem_q[raddr];
  end

  // rdata_live_q masks the unreset read register until the first read.
  logic rvalid_q, rdata_live_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q     <= 1'b0;
      rdata_live_q <= 1'b0;
    end else begin
      rvalid_q <= rd_any;
      if (rd_any) rdata_live_q <= 1'b1;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_live_q ? rd_word_q : '0;

endmodule

// File: doc/fifo_sync_multi.md
FIFO_SYNC_MULTI -- requirements
Module: fifo_sync_multi

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter pDEPTH, default 512, words per channel; power of two, >= 4.
REQ-003 SHALL have parameter pCHANNELS, default 4, number of independent logical FIFOs; >= 1. CW = max(1, clog2(pCHANNELS)); AW = clog2(pDEPTH).
REQ-004 SHALL have ports (one clock; reset asynchronous, active-high):
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous active-high reset.
- full_threshold_value  in  32  fill level at or above which full_threshold asserts.
- empty_threshold_value  in  32  fill level at or below which empty_threshold asserts.
- clear  in  pCHANNELS  per-channel synchronous flush.
- wen  in  1  write strobe.
- wchan  in  CW  write channel select.
- wdata  in  pDATA_WIDTH  write data.
- ren  in  1  read strobe.
- rchan  in  CW  read channel select.
- rdata  out  pDATA_WIDTH  read data, registered.
- rvalid  out  1  rdata updated this cycle.
- rlevel  out  AW+1  current fill count of channel rchan.
- full, almost_full, full_threshold, overflow  out  pCHANNELS  per-channel write-side status.
- empty, almost_empty, empty_threshold, underflow  out  pCHANNELS  per-channel read-side status.

Function
REQ-005 SHALL keep, per channel, a write pointer, a read pointer (AW bits, wrapping pDEPTH-1 -> 0) and a count (AW+1 bits, 0..pDEPTH).
REQ-006 SHALL treat a write as accepted when wen=1, wchan < pCHANNELS, count[wchan] < pDEPTH and clear[wchan]=0; an accepted write stores wdata and increments that channel's write pointer.
REQ-007 SHALL treat a read as accepted when ren=1, rchan < pCHANNELS, count[rchan] > 0 and clear[rchan]=0; rdata SHALL present the word at the read pointer on the next cycle with rvalid=1 for exactly one cycle. Latency is 1 cycle.
REQ-008 SHALL hold rdata unchanged and keep rvalid=0 in any cycle following no accepted read.
REQ-009 SHALL evaluate acceptance on pre-edge counts: a write to a full channel SHALL be dropped even if the same channel is read that cycle; a read of an empty channel SHALL be dropped even if the same channel is written that cycle.
REQ-010 SHALL, on accepted read and write to the same channel in one cycle, leave that count unchanged; on different channels, update each independently.
REQ-011 SHALL set overflow[c] on a dropped write to full channel c and underflow[c] on a dropped read of empty channel c; both sticky until clear[c] or reset.
REQ-012 SHALL ignore (no storage, no flags) wen/ren with channel index >= pCHANNELS.
REQ-013 SHALL derive status from registered counts: full = (count==pDEPTH); empty = (count==0); almost_full = (count==pDEPTH-1); almost_empty = (count==1); full_threshold = (count >= full_threshold_value); empty_threshold = (count <= empty_threshold_value); 32-bit unsigned compares, count zero-extended.
REQ-014 SHALL reflect an accepted operation in count, status flags and rlevel on the cycle after the edge that accepted it.
REQ-015 SHALL, on clear[c]=1, zero channel c's pointers and count and deassert overflow[c]/underflow[c] at the next edge; clear overrides wen/ren on channel c that cycle, and a read so suppressed SHALL NOT set underflow or rvalid.
REQ-016 SHALL let clear on one channel leave all other channels' state and traffic unaffected.
REQ-017 SHALL compute rlevel combinationally from count[rchan]; rlevel = 0 when rchan >= pCHANNELS.
REQ-018 SHALL use an inferred memory of pCHANNELS*pDEPTH words addressed {channel, pointer}; one write port, one read port.

Reset
REQ-019 SHALL, while reset=1 (asynchronous assert, synchronous-to-clk effect on release), force all pointers and counts to 0, rdata=0, rvalid=0, overflow=0, underflow=0, empty=all ones, full/almost_full/almost_empty=0; thresholds per REQ-013 from count 0.
REQ-020 SHALL discard all contents on reset asserted mid-operation; the first accepted read after reset returns the first word written after reset.

Verification
REQ-021 Reset, then write 0x0001..0x0200 to ch1 -> full[1]=1, almost_full[1]=0, full_threshold[1]=1, other channels empty=1; write 0xFFFF to ch1 -> dropped, overflow[1]=1.
REQ-022 Read 512 words from ch1 -> rdata 0x0001..0x0200 in order, one cycle after each ren, rvalid pulses 512 times; then one more ren -> rvalid=0, underflow[1]=1, rdata stays 0x0200.
REQ-023 Thresholds 384/128: fill ch0 to 383 -> full_threshold[0]=0; 384th write -> 1 next cycle; drain to 128 -> empty_threshold[0]=1, at 129 -> 0.
REQ-024 ch2 empty, same-cycle wen+ren to ch2 -> write accepted, read dropped, underflow[2]=1, count=1; ch2 full, same-cycle wen+ren -> read accepted, write dropped, overflow[2]=1, count=511.
REQ-025 ch3 holding 10 words, ch0 holding 5: assert clear[3] with ren to ch3 -> count[3]=0, empty[3]=1, rvalid=0, underflow[3]=0; ch0 still 5 words, data intact.
REQ-026 Reset asserted mid-burst with ch0 half full -> all outputs at REQ-019 values asynchronously; after release write 0xA5A5, read -> rdata=0xA5A5.
